// File: rtl/noc_router_param.sv
// Parametrised 5-port mesh router: two polarity-phased VCs, per-input FIFOs, XY routing, per-output RR.
// Optional NOC_ROUTER_STATS_EN adds per-output sent counters (stats) and a sticky out-of-range flag (oor_err).
module noc_router_param #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned X_W    = 2,
    parameter int unsigned Y_W    = 2,
    parameter int unsigned MESH_X = 4,
    parameter int unsigned MESH_Y = 4,
    parameter int unsigned MY_X   = 0,
    parameter int unsigned MY_Y   = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4:0]          si,
    input  logic [5*DATA_W-1:0] packet_in,
    output logic [4:0]          ri,
    output logic [4:0]          so,
    output logic [5*DATA_W-1:0] packet_out,
    input  logic [4:0]          ro,
    output logic                polarity
`ifdef NOC_ROUTER_STATS_EN
    ,
    output logic [5*16-1:0]     stats,
    output logic                oor_err
`endif
);

    localparam int unsigned NP    = 5;
    localparam int unsigned P_E   = 0;
    localparam int unsigned P_W   = 1;
    localparam int unsigned P_S   = 2;
    localparam int unsigned P_N   = 3;
    localparam int unsigned P_PE  = 4;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem    [NP][2][DEPTH];
    logic [PTR_W-1:0]  wr_ptr [NP][2];
    logic [PTR_W-1:0]  rd_ptr [NP][2];
    logic [CNT_W-1:0]  count  [NP][2];

    logic              vc_in;
    logic              vc_out;
    logic [NP-1:0]     push;
    logic [NP-1:0]     pop;
    logic [DATA_W-1:0] head       [NP];
    logic [NP-1:0]     head_valid;
    logic [2:0]        head_route [NP];
    logic [2:0]        rr         [NP];
    logic [NP-1:0]     win_valid;
    logic [2:0]        win_idx    [NP];

    function automatic logic is_oor(input logic [DATA_W-1:0] pkt);
        return (32'(pkt[DATA_W-1 -: X_W]) >= MESH_X) ||
               (32'(pkt[DATA_W-1-X_W -: Y_W]) >= MESH_Y);
    endfunction

    // XY dimension-order route; out-of-range destinations eject locally
    function automatic logic [2:0] route_of(input logic [DATA_W-1:0] pkt);
        logic [31:0] dx;
        logic [31:0] dy;
        dx = 32'(pkt[DATA_W-1 -: X_W]);
        dy = 32'(pkt[DATA_W-1-X_W -: Y_W]);
        if (is_oor(pkt))  return 3'(P_PE);
        else if (dx > MY_X) return 3'(P_E);
        else if (dx < MY_X) return 3'(P_W);
        else if (dy > MY_Y) return 3'(P_N);
        else if (dy < MY_Y) return 3'(P_S);
        else                return 3'(P_PE);
    endfunction

    assign vc_in  = polarity;
    assign vc_out = ~polarity;

    // Input side: accept into the current-phase VC unless it is full
    always_comb begin
        ri   = '0;
        push = '0;
        for (int unsigned k = 0; k < NP; k++) begin
            ri[k]   = reset && (count[k][vc_in] != CNT_W'(DEPTH));
            push[k] = si[k] && ri[k];
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < NP; k++) begin
            head[k]       = mem[k][vc_out][rd_ptr[k][vc_out]];
            head_valid[k] = (count[k][vc_out] != '0);
            head_route[k] = route_of(head[k]);
        end
    end

    // Round-robin: first valid head routed to o at or after rr[o]
    always_comb begin
        int unsigned c;
        c         = 0;
        win_valid = '0;
        for (int unsigned o = 0; o < NP; o++) begin
            win_idx[o] = '0;
            for (int unsigned j = 0; j < NP; j++) begin
                c = (32'(rr[o]) + j) % NP;
                if (!win_valid[o] && head_valid[c] && (head_route[c] == 3'(o))) begin
                    win_valid[o] = 1'b1;
                    win_idx[o]   = 3'(c);
                end
            end
        end
    end

    always_comb begin
        so         = '0;
        pop        = '0;
        packet_out = '0;
        for (int unsigned o = 0; o < NP; o++) begin
            so[o] = win_valid[o] && ro[o];
            if (so[o]) begin
                packet_out[o*DATA_W +: DATA_W] = head[win_idx[o]];
                pop[win_idx[o]]                = 1'b1;
            end
        end
    end

    // Push and pop always address opposite VCs, so each counter sees one direction per cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            polarity <= 1'b0;
            for (int unsigned k = 0; k < NP; k++) begin
                rr[k] <= '0;
                for (int unsigned v = 0; v < 2; v++) begin
                    wr_ptr[k][v] <= '0;
                    rd_ptr[k][v] <= '0;
                    count[k][v]  <= '0;
                end
            end
        end else begin
            polarity <= ~polarity;
            for (int unsigned k = 0; k < NP; k++) begin
                if (push[k]) begin
                    wr_ptr[k][vc_in] <= wr_ptr[k][vc_in] + PTR_W'(1);
                    count[k][vc_in]  <= count[k][vc_in] + CNT_W'(1);
                end
                if (pop[k]) begin
                    rd_ptr[k][vc_out] <= rd_ptr[k][vc_out] + PTR_W'(1);
                    count[k][vc_out]  <= count[k][vc_out] - CNT_W'(1);
                end
            end
            for (int unsigned o = 0; o < NP; o++) begin
                if (so[o]) rr[o] <= (win_idx[o] == 3'd4) ? 3'd0 : win_idx[o] + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < NP; k++) begin
            if (push[k]) mem[k][vc_in][wr_ptr[k][vc_in]] <= packet_in[k*DATA_W +: DATA_W];
        end
    end

`ifdef NOC_ROUTER_STATS_EN
    logic [NP-1:0] head_oor;

    always_comb begin
        for (int unsigned k = 0; k < NP; k++) head_oor[k] = is_oor(head[k]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stats   <= '0;
            oor_err <= 1'b0;
        end else begin
            for (int unsigned o = 0; o < NP; o++) begin
                if (so[o] && (stats[o*16 +: 16] != 16'hFFFF))
                    stats[o*16 +: 16] <= stats[o*16 +: 16] + 16'd1;
            end
            if (so[P_PE] && head_oor[win_idx[P_PE]]) oor_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_noc_router_param.sv
// Self-checking bench for noc_router_param at node (1,1) of a 4x4 mesh, 32-bit packets.
// Queue-based reference model checked every cycle, plus directed literal checks.
module tb_noc_router_param;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int MX    = 4;
    localparam int MYY   = 4;
    localparam int ME_X  = 1;
    localparam int ME_Y  = 1;

    logic            clk = 1'b0;
    logic            reset;
    logic [4:0]      si;
    logic [5*DW-1:0] packet_in;
    logic [4:0]      ri;
    logic [4:0]      so;
    logic [5*DW-1:0] packet_out;
    logic [4:0]      ro;
    logic            polarity;
`ifdef NOC_ROUTER_STATS_EN
    logic [5*16-1:0] stats;
    logic            oor_err;
`endif

    noc_router_param #(
        .DATA_W(DW), .DEPTH(DEPTH), .X_W(3), .Y_W(3),
        .MESH_X(MX), .MESH_Y(MYY), .MY_X(ME_X), .MY_Y(ME_Y)
    ) dut (
        .clk(clk), .reset(reset), .si(si), .packet_in(packet_in), .ri(ri),
        .so(so), .packet_out(packet_out), .ro(ro), .polarity(polarity)
`ifdef NOC_ROUTER_STATS_EN
        , .stats(stats), .oor_err(oor_err)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [DW-1:0] q [5][2][$];
    int            m_pol;
    int            m_rr [5];
    int            m_stats [5];
    bit            m_oor;

    logic [4:0]      obs_ri;
    logic [4:0]      obs_so;
    logic [5*DW-1:0] obs_pk;
    logic            obs_pol;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mk(input int dx, input int dy, input int pay);
        logic [DW-1:0] r;
        r = {3'(dx), 3'(dy), 26'(pay)};
        return r;
    endfunction

    function automatic bit oor_of(input logic [DW-1:0] pk);
        return (int'(pk[31:29]) >= MX) || (int'(pk[28:26]) >= MYY);
    endfunction

    function automatic int route(input logic [DW-1:0] pk);
        int dx;
        int dy;
        dx = int'(pk[31:29]);
        dy = int'(pk[28:26]);
        if (oor_of(pk)) return 4;
        if (dx > ME_X) return 0;
        if (dx < ME_X) return 1;
        if (dy > ME_Y) return 3;
        if (dy < ME_Y) return 2;
        return 4;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 5; k++) begin
            q[k][0].delete();
            q[k][1].delete();
            m_rr[k]    = 0;
            m_stats[k] = 0;
        end
        m_pol = 0;
        m_oor = 1'b0;
    endtask

    task automatic set_pkt(input int k, input logic [DW-1:0] v);
        packet_in[k*DW +: DW] = v;
    endtask

    // One clock: compare at negedge against the model, advance the model at posedge
    task automatic step();
        logic [4:0]    e_ri;
        logic [4:0]    e_so;
        logic [DW-1:0] e_pk [5];
        logic [DW-1:0] pin  [5];
        logic [4:0]    s_si;
        int            win  [5];
        int            p;
        int            c;
        @(negedge clk);
        p = m_pol;
        for (int k = 0; k < 5; k++) e_ri[k] = (q[k][p].size() < DEPTH);
        for (int o = 0; o < 5; o++) begin
            win[o] = -1;
            for (int j = 0; j < 5; j++) begin
                c = (m_rr[o] + j) % 5;
                if (win[o] < 0 && q[c][1-p].size() > 0)
                    if (route(q[c][1-p][0]) == o) win[o] = c;
            end
            e_so[o] = (win[o] >= 0) && ro[o];
            e_pk[o] = e_so[o] ? q[win[o]][1-p][0] : '0;
        end
        obs_ri  = ri;
        obs_so  = so;
        obs_pk  = packet_out;
        obs_pol = polarity;
        chk("polarity", 64'(polarity), 64'(p));
        chk("ri", 64'(ri), 64'(e_ri));
        chk("so", 64'(so), 64'(e_so));
        for (int o = 0; o < 5; o++) chk($sformatf("packet_out[%0d]", o), 64'(packet_out[o*DW +: DW]), 64'(e_pk[o]));
`ifdef NOC_ROUTER_STATS_EN
        for (int o = 0; o < 5; o++) chk($sformatf("stats[%0d]", o), 64'(stats[o*16 +: 16]), 64'(m_stats[o]));
        chk("oor_err", 64'(oor_err), 64'(m_oor));
`endif
        s_si = si;
        for (int k = 0; k < 5; k++) pin[k] = packet_in[k*DW +: DW];
        @(posedge clk);
        for (int o = 0; o < 5; o++) begin
            if (e_so[o]) begin
                if (o == 4 && oor_of(e_pk[o])) m_oor = 1'b1;
                void'(q[win[o]][1-p].pop_front());
                m_rr[o] = (win[o] + 1) % 5;
                if (m_stats[o] < 16'hFFFF) m_stats[o]++;
            end
        end
        for (int k = 0; k < 5; k++) if (s_si[k] && e_ri[k]) q[k][p].push_back(pin[k]);
        m_pol = 1 - p;
        #1;
    endtask

    initial begin
        int accepted;
        int got;
        int cyc;
        int vc0;
        reset     = 1'b0;
        si        = '0;
        ro        = '0;
        packet_in = '0;
        model_reset();

        // Reset held low
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ri", 64'(ri), 64'd0);
        chk("rst_so", 64'(so), 64'd0);
        chk("rst_pkt", 64'(packet_out[63:0] | packet_out[127:64] | 64'(packet_out[159:128])), 64'd0);
        chk("rst_pol", 64'(polarity), 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        ro = '1;

        step();
        chk("first_ri", 64'(obs_ri), 64'h1f);
        chk("first_pol", 64'(obs_pol), 64'd0);
        step();
        chk("second_pol", 64'(obs_pol), 64'd1);

        // PE -> E, identical packet one cycle later
        set_pkt(4, mk(3, 1, 'hABCD));
        si = 5'b10000;
        step();
        chk("t1_accept", 64'(obs_ri[4]), 64'd1);
        si = '0;
        step();
        chk("t1_so", 64'(obs_so), 64'h01);
        chk("t1_pkt", 64'(obs_pk[0 +: DW]), 64'(mk(3, 1, 'hABCD)));
        step();
        chk("t1_drained", 64'(obs_so), 64'h00);

        // W -> PE (local) and N -> S simultaneously
        set_pkt(1, mk(1, 1, 'h111));
        set_pkt(3, mk(1, 0, 'h333));
        si = 5'b01010;
        step();
        si = '0;
        step();
        chk("t2_so", 64'(obs_so), 64'h14);
        chk("t2_pe", 64'(obs_pk[4*DW +: DW]), 64'(mk(1, 1, 'h111)));
        chk("t2_s", 64'(obs_pk[2*DW +: DW]), 64'(mk(1, 0, 'h333)));

        // Contention on N from W, S, PE
        set_pkt(1, mk(1, 3, 'h1));
        set_pkt(2, mk(1, 3, 'h2));
        set_pkt(4, mk(1, 3, 'h4));
        si = 5'b10110;
        step();
        si = '0;
        step(); chk("t3_c1_so", 64'(obs_so[3]), 64'd1); chk("t3_c1_pkt", 64'(obs_pk[3*DW +: DW]), 64'(mk(1, 3, 'h1)));
        step(); chk("t3_c2_so", 64'(obs_so[3]), 64'd0);
        step(); chk("t3_c3_so", 64'(obs_so[3]), 64'd1); chk("t3_c3_pkt", 64'(obs_pk[3*DW +: DW]), 64'(mk(1, 3, 'h2)));
        step(); chk("t3_c4_so", 64'(obs_so[3]), 64'd0);
        step(); chk("t3_c5_so", 64'(obs_so[3]), 64'd1); chk("t3_c5_pkt", 64'(obs_pk[3*DW +: DW]), 64'(mk(1, 3, 'h4)));
        // rr[N] back at 0: E beats PE
        set_pkt(0, mk(1, 3, 'hE0));
        set_pkt(4, mk(1, 3, 'hE4));
        si = 5'b10001;
        step();
        si = '0;
        step(); chk("t3_rr_pkt", 64'(obs_pk[3*DW +: DW]), 64'(mk(1, 3, 'hE0)));
        step();
        step(); chk("t3_rr_pkt2", 64'(obs_pk[3*DW +: DW]), 64'(mk(1, 3, 'hE4)));

        // Backpressure: S streams 10 packets to a stalled N
        ro       = 5'b10111;
        accepted = 0;
        cyc      = 0;
        vc0      = 0;
        while (accepted < 8 && cyc < 40) begin
            set_pkt(2, mk(1, 3, 'h100 + accepted));
            si = 5'b00100;
            if (accepted == 0) vc0 = m_pol;
            step();
            if (obs_ri[2]) accepted++;
            cyc++;
        end
        chk("bp_accepts", 64'(accepted), 64'd8);
        set_pkt(2, mk(1, 3, 'h100 + accepted));
        step();
        chk("bp_ri_low", 64'(obs_ri[2]), 64'd0);
        if (m_pol == vc0) step();
        ro  = '1;
        got = 0;
        cyc = 0;
        while (got < 10 && cyc < 60) begin
            set_pkt(2, mk(1, 3, 'h100 + accepted));
            si = (accepted < 10) ? 5'b00100 : 5'b00000;
            step();
            if (obs_ri[2] && si[2]) accepted++;
            if (obs_so[3]) begin
                chk("bp_order", 64'(obs_pk[3*DW +: DW]), 64'(mk(1, 3, 'h100 + got)));
                got++;
            end
            cyc++;
        end
        chk("bp_all_out", 64'(got), 64'd10);
        chk("bp_all_in", 64'(accepted), 64'd10);
        si = '0;

        // Asynchronous reset mid-operation with buffered traffic
        ro = '0;
        for (int k = 0; k < 5; k++) set_pkt(k, mk(k % 4, 3, 'h200 + k));
        si = 5'b11111;
        step();
        si = '0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_ri", 64'(ri), 64'd0);
        chk("mid_rst_so", 64'(so), 64'd0);
        chk("mid_rst_pol", 64'(polarity), 64'd0);
        ro = '1;
        #1;
        chk("mid_rst_so_ro", 64'(so), 64'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Out-of-range destination ejects locally
        set_pkt(4, mk(5, 0, 'h55));
        si = 5'b10000;
        step();
        si = '0;
        step();
        chk("oor_so", 64'(obs_so), 64'h10);
        chk("oor_pkt", 64'(obs_pk[4*DW +: DW]), 64'(mk(5, 0, 'h55)));
        step();
`ifdef NOC_ROUTER_STATS_EN
        chk("oor_flag", 64'(oor_err), 64'd1);
        chk("oor_stats_pe", 64'(stats[4*16 +: 16]), 64'd1);
`endif

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            si = 5'($urandom);
            ro = 5'($urandom) | 5'($urandom);
            for (int k = 0; k < 5; k++)
                set_pkt(k, mk($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 'hFFFF)));
            step();
        end
        si = '0;
        ro = '1;
        repeat (20) step();
        for (int k = 0; k < 5; k++)
            chk($sformatf("drain_empty[%0d]", k), 64'(q[k][0].size() + q[k][1].size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
